denise_ham_engine: RTL and testbench

Parametrised HAM/palette pixel engine for the Denise video path, successor to the fixed 12-bit HAM6 generator. It owns a banked palette RAM and a two-stage pixel pipeline, and it supports plain palette lookup, HAM6 and optional HAM8. It also supports 12-bit (OCS/ECS) or 24-bit (AGA) colour with split high/low nibble palette writes. The hold register is re-seeded from the border colour during blanking. It sits between the bitplane shifter/sprite priority logic and the video output mux.

---
 rtl/denise_ham_engine_if.sv | 29 ++
 rtl/denise_ham_engine.sv | 147 ++++++++++++++
 tb/tb_denise_ham_engine.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/denise_ham_engine_if.sv
// Pixel/register bus between the bitplane front end and denise_ham_engine.
interface denise_ham_engine_if #(
  parameter int CW = 8
);
  logic              clk7_en;
  logic [8:1]        reg_address_in;
  logic [11:0]       data_in;
  logic [2:0]        bank;
  logic              loct;
  logic              ham_en;
  logic              ham8;
  logic              blank;
  logic              pix_en;
  logic [7:0]        bpldata;
  logic [3*CW-1:0]   rgb;
  logic              rgb_valid;

  modport master (
    output clk7_en, reg_address_in, data_in, bank, loct,
    output ham_en, ham8, blank, pix_en, bpldata,
    input  rgb, rgb_valid
  );

  modport slave (
    input  clk7_en, reg_address_in, data_in, bank, loct,
    input  ham_en, ham8, blank, pix_en, bpldata,
    output rgb, rgb_valid
  );
endinterface

// File: rtl/denise_ham_engine.sv
// Banked palette + two-stage HAM/palette pixel pipeline for Denise.
// HAM8 decode is compiled in only when DENISE_HAM8_EN is defined.
module denise_ham_engine #(
  parameter int CW   = 8,
  parameter int IDXW = 8
) (
  input  logic              clk,
  input  logic              reset,
  denise_ham_engine_if.slave bus
);
  localparam int RGBW  = 3 * CW;
  localparam int DEPTH = 1 << IDXW;

  logic [RGBW-1:0] r_pal [DEPTH];

  logic            r_s1_vld;
  logic [7:0]      r_s1_bpl;
  logic            r_s1_ham;
  logic            r_s1_ham8;
  logic            r_s1_blank;
  logic [RGBW-1:0] r_s1_pal;
  logic [RGBW-1:0] r_rgb;
  logic            r_rgb_valid;

  logic [7:0]      w_wr_full;
  logic [IDXW-1:0] w_wr_idx;
  logic            w_pal_we;
  logic [RGBW-1:0] w_wr_old;
  logic [RGBW-1:0] w_wr_data;
  logic            w_ham8;
  logic [IDXW-1:0] w_rd_idx;
  logic [1:0]      w_ctl;
  logic [CW-1:0]   w_held_r;
  logic [CW-1:0]   w_held_g;
  logic [CW-1:0]   w_held_b;
  logic [CW-1:0]   w_mod_r;
  logic [CW-1:0]   w_mod_g;
  logic [CW-1:0]   w_mod_b;
  logic [RGBW-1:0] w_next_rgb;

`ifdef DENISE_HAM8_EN
  assign w_ham8 = bus.ham8;
`else
  assign w_ham8 = 1'b0;
`endif

  assign w_pal_we  = bus.clk7_en && (bus.reg_address_in[8:6] == 3'b110) && !reset;
  assign w_wr_full = {bus.bank, bus.reg_address_in[5:1]};
  assign w_wr_idx  = w_wr_full[IDXW-1:0];
  assign w_wr_old  = r_pal[w_wr_idx];

  assign w_held_r = r_rgb[RGBW-1:2*CW];
  assign w_held_g = r_rgb[2*CW-1:CW];
  assign w_held_b = r_rgb[CW-1:0];
  assign w_ctl    = r_s1_ham8 ? r_s1_bpl[1:0] : r_s1_bpl[5:4];

  if (CW == 8) begin : g_cw8
    // LOCT writes merge into the existing high nibbles; normal writes duplicate the nibble.
    assign w_wr_data = bus.loct ?
        {w_wr_old[23:20], bus.data_in[11:8], w_wr_old[15:12], bus.data_in[7:4],
         w_wr_old[7:4],   bus.data_in[3:0]} :
        {bus.data_in[11:8], bus.data_in[11:8], bus.data_in[7:4], bus.data_in[7:4],
         bus.data_in[3:0],  bus.data_in[3:0]};
    assign w_mod_r = r_s1_ham8 ? {r_s1_bpl[7:2], r_rgb[17:16]} : {r_s1_bpl[3:0], r_s1_bpl[3:0]};
    assign w_mod_g = r_s1_ham8 ? {r_s1_bpl[7:2], r_rgb[9:8]}   : {r_s1_bpl[3:0], r_s1_bpl[3:0]};
    assign w_mod_b = r_s1_ham8 ? {r_s1_bpl[7:2], r_rgb[1:0]}   : {r_s1_bpl[3:0], r_s1_bpl[3:0]};
  end else begin : g_cw4
    assign w_wr_data = bus.data_in;
    assign w_mod_r   = r_s1_ham8 ? r_s1_bpl[7:4] : r_s1_bpl[3:0];
    assign w_mod_g   = w_mod_r;
    assign w_mod_b   = w_mod_r;
  end

  // Stage-1 palette read index selection.
  always_comb begin
    w_rd_idx = {IDXW{1'b0}};
    if (bus.blank) begin
      w_rd_idx = {IDXW{1'b0}};
    end else if (bus.ham_en && w_ham8) begin
      w_rd_idx = IDXW'(bus.bpldata[7:2]);
    end else if (bus.ham_en) begin
      w_rd_idx = IDXW'(bus.bpldata[3:0]);
    end else begin
      w_rd_idx = bus.bpldata[IDXW-1:0];
    end
  end

  // Palette write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_pal_we) begin
      r_pal[w_wr_idx] <= w_wr_data;
    end
  end

  // Stage 1: capture pixel attributes and read the palette (old data on a same-cycle write).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_bpl   <= 8'h00;
      r_s1_ham   <= 1'b0;
      r_s1_ham8  <= 1'b0;
      r_s1_blank <= 1'b0;
      r_s1_pal   <= {RGBW{1'b0}};
    end else begin
      r_s1_vld <= bus.pix_en;
      if (bus.pix_en) begin
        r_s1_bpl   <= bus.bpldata;
        r_s1_ham   <= bus.ham_en;
        r_s1_ham8  <= w_ham8;
        r_s1_blank <= bus.blank;
        r_s1_pal   <= r_pal[w_rd_idx];
      end
    end
  end

  // Stage-2 colour: palette load or single-component modify of the held colour.
  always_comb begin
    w_next_rgb = r_s1_pal;
    if (r_s1_blank || !r_s1_ham) begin
      w_next_rgb = r_s1_pal;
    end else begin
      case (w_ctl)
        2'b00:   w_next_rgb = r_s1_pal;
        2'b01:   w_next_rgb = {w_held_r, w_held_g, w_mod_b};
        2'b10:   w_next_rgb = {w_mod_r,  w_held_g, w_held_b};
        2'b11:   w_next_rgb = {w_held_r, w_mod_g,  w_held_b};
        default: w_next_rgb = r_s1_pal;
      endcase
    end
  end

  // Stage 2: the output register doubles as the HAM hold register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb       <= {RGBW{1'b0}};
      r_rgb_valid <= 1'b0;
    end else begin
      r_rgb_valid <= r_s1_vld;
      if (r_s1_vld) begin
        r_rgb <= w_next_rgb;
      end
    end
  end

  assign bus.rgb       = r_rgb;
  assign bus.rgb_valid = r_rgb_valid;
endmodule

// File: tb/tb_denise_ham_engine.sv
// Directed scoreboard bench for denise_ham_engine (CW=8, IDXW=8).
module tb_denise_ham_engine;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [23:0] exp_q[$];

  denise_ham_engine_if #(.CW(8)) bus ();

  denise_ham_engine #(.CW(8), .IDXW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %06h expected %06h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample just after the edge and score any valid pixel.
  task automatic step();
    logic [23:0] e;
    @(posedge clk);
    #1;
    if (bus.rgb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", {23'd0, bus.rgb_valid}, 24'd0);
      end else begin
        e = exp_q.pop_front();
        check("pixel", bus.rgb, e);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) step();
    check("drain_timeout", 24'(exp_q.size()), 24'd0);
  endtask

  task automatic pal_write(input logic [8:0] addr, input logic [11:0] data,
                           input logic [2:0] bk, input logic lo);
    bus.clk7_en        = 1'b1;
    bus.reg_address_in = addr[8:1];
    bus.data_in        = data;
    bus.bank           = bk;
    bus.loct           = lo;
    step();
    bus.clk7_en        = 1'b0;
  endtask

  task automatic pixel(input logic [7:0] bpl, input logic ham, input logic h8,
                       input logic blk, input logic [23:0] exp);
    bus.pix_en  = 1'b1;
    bus.bpldata = bpl;
    bus.ham_en  = ham;
    bus.ham8    = h8;
    bus.blank   = blk;
    exp_q.push_back(exp);
    step();
    bus.pix_en  = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.clk7_en = 1'b0; bus.reg_address_in = 8'h00; bus.data_in = 12'h000;
    bus.bank = 3'd0; bus.loct = 1'b0; bus.ham_en = 1'b0; bus.ham8 = 1'b0;
    bus.blank = 1'b0; bus.pix_en = 1'b0; bus.bpldata = 8'h00;

    repeat (3) step();
    check("reset_rgb", bus.rgb, 24'h000000);
    check("reset_valid", {23'd0, bus.rgb_valid}, 24'd0);
    reset = 1'b0;
    step();

    // Normal write then blank pixel, valid must be a single-cycle pulse.
    pal_write(9'h180, 12'hF80, 3'd0, 1'b0);
    pixel(8'h00, 1'b0, 1'b0, 1'b1, 24'hFF8800);
    drain();
    step();
    check("valid_pulse", {23'd0, bus.rgb_valid}, 24'd0);
    repeat (3) step();
    check("idle_hold", bus.rgb, 24'hFF8800);

    // Low-nibble write keeps the high nibbles.
    pal_write(9'h180, 12'h123, 3'd0, 1'b1);
    pixel(8'h00, 1'b0, 1'b0, 1'b1, 24'hF18203);
    drain();

    // HAM6 back-to-back sequence.
    pal_write(9'h180, 12'hF80, 3'd0, 1'b0);
    pixel(8'h00, 1'b1, 1'b0, 1'b0, 24'hFF8800);
    pixel(8'h15, 1'b1, 1'b0, 1'b0, 24'hFF8855);
    pixel(8'h2A, 1'b1, 1'b0, 1'b0, 24'hAA8855);
    pixel(8'h33, 1'b1, 1'b0, 1'b0, 24'hAA3355);
    drain();

    // HAM8 modify, or HAM6 decode of the same byte when HAM8 is not built.
    pixel(8'h00, 1'b1, 1'b1, 1'b0, 24'hFF8800);
`ifdef DENISE_HAM8_EN
    pixel(8'hFD, 1'b1, 1'b1, 1'b0, 24'hFF88FC);
`else
    pixel(8'hFD, 1'b1, 1'b1, 1'b0, 24'hFFDD00);
`endif
    drain();

    // Direct lookups, banked write, blank override and a per-pixel mode change.
    pal_write(9'h18A, 12'h0F0, 3'd0, 1'b0);
    pal_write(9'h182, 12'hABC, 3'd1, 1'b0);
    pixel(8'h05, 1'b0, 1'b0, 1'b0, 24'h00FF00);
    pixel(8'h21, 1'b0, 1'b0, 1'b0, 24'hAABBCC);
    pixel(8'h21, 1'b0, 1'b0, 1'b1, 24'hFF8800);
    pixel(8'h05, 1'b0, 1'b0, 1'b0, 24'h00FF00);
    pixel(8'h1F, 1'b1, 1'b0, 1'b0, 24'h00FFFF);
    drain();

    // Same-cycle write and read of entry 5: old value first, new value next.
    bus.clk7_en = 1'b1; bus.reg_address_in = 8'hC5; bus.data_in = 12'h00F;
    bus.bank = 3'd0; bus.loct = 1'b0;
    pixel(8'h05, 1'b0, 1'b0, 1'b0, 24'h00FF00);
    bus.clk7_en = 1'b0;
    pixel(8'h05, 1'b0, 1'b0, 1'b0, 24'h0000FF);
    drain();
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_rgb", bus.rgb, 24'h0000FF);
      check("hold_valid", {23'd0, bus.rgb_valid}, 24'd0);
    end

    // Mid-line reset with an ignored palette write to entry 5.
    pixel(8'h2F, 1'b1, 1'b0, 1'b0, 24'hFF00FF);
    drain();
    reset = 1'b1;
    bus.clk7_en = 1'b1; bus.reg_address_in = 8'hC5; bus.data_in = 12'hF00;
    step();
    bus.clk7_en = 1'b0;
    check("midreset_rgb", bus.rgb, 24'h000000);
    check("midreset_valid", {23'd0, bus.rgb_valid}, 24'd0);
    step();
    reset = 1'b0;
    pixel(8'h1F, 1'b1, 1'b0, 1'b0, 24'h0000FF);
    pixel(8'h25, 1'b1, 1'b0, 1'b0, 24'h5500FF);
    pixel(8'h05, 1'b0, 1'b0, 1'b0, 24'h0000FF);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
